// File: rtl/ram_port_arbiter.sv
`default_nettype none
// ram_port_arbiter: round-robin sharing of one simple dual-port RAM between two
// writers and two readers, with registered RAM side and write-before-read ordering.
module ram_port_arbiter #(
  parameter  int SIZE  = 8,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            w0_req,
  input  logic [AW-1:0]   w0_addr,
  input  logic [SIZE-1:0] w0_data,
  output logic            w0_grant,
  input  logic            w1_req,
  input  logic [AW-1:0]   w1_addr,
  input  logic [SIZE-1:0] w1_data,
  output logic            w1_grant,
  input  logic            r0_req,
  input  logic [AW-1:0]   r0_addr,
  output logic            r0_grant,
  output logic            r0_valid,
  output logic [SIZE-1:0] r0_data,
  input  logic            r1_req,
  input  logic [AW-1:0]   r1_addr,
  output logic            r1_grant,
  output logic            r1_valid,
  output logic [SIZE-1:0] r1_data,
  output logic [AW-1:0]   ram_waddr,
  output logic [SIZE-1:0] ram_write_data,
  output logic            ram_write_en,
  output logic [AW-1:0]   ram_raddr,
  input  logic [SIZE-1:0] ram_read_data
);

  logic            wptr_q, wptr_d;
  logic            rptr_q, rptr_d;
  logic [AW-1:0]   ram_waddr_q, ram_waddr_d;
  logic [SIZE-1:0] ram_write_data_q, ram_write_data_d;
  logic            ram_write_en_q, ram_write_en_d;
  logic [AW-1:0]   ram_raddr_q, ram_raddr_d;
  logic            tag1_vld_q, tag1_vld_d, tag1_id_q, tag1_id_d;
  logic            tag2_vld_q, tag2_vld_d, tag2_id_q, tag2_id_d;

  logic            w_any, w_sel;
  logic [AW-1:0]   w_addr;
  logic [SIZE-1:0] w_data;
  logic            r0_elig, r1_elig, r_any, r_sel;
  logic [AW-1:0]   r_addr;

  // Grants: the pointer names the preferred requester when both compete.
  always_comb begin
    w0_grant = w0_req & (~w1_req | ~wptr_q);
    w1_grant = w1_req & (~w0_req |  wptr_q);
    w_any    = w0_grant | w1_grant;
    w_sel    = w1_grant;
    w_addr   = w_sel ? w1_addr : w0_addr;
    w_data   = w_sel ? w1_data : w0_data;
    // A reader hitting the address being written this cycle waits one cycle,
    // so the RAM never reads an address in the cycle it commits to it.
    r0_elig  = r0_req & ~(w_any & (r0_addr == w_addr));
    r1_elig  = r1_req & ~(w_any & (r1_addr == w_addr));
    r0_grant = r0_elig & (~r1_elig | ~rptr_q);
    r1_grant = r1_elig & (~r0_elig |  rptr_q);
    r_any    = r0_grant | r1_grant;
    r_sel    = r1_grant;
    r_addr   = r_sel ? r1_addr : r0_addr;
  end

  always_comb begin
    wptr_d           = w_any ? ~w_sel : wptr_q;
    rptr_d           = r_any ? ~r_sel : rptr_q;
    ram_write_en_d   = w_any;
    ram_waddr_d      = w_any ? w_addr : ram_waddr_q;
    ram_write_data_d = w_any ? w_data : ram_write_data_q;
    ram_raddr_d      = r_any ? r_addr : ram_raddr_q;
    tag1_vld_d       = r_any;
    tag1_id_d        = r_sel;
    tag2_vld_d       = tag1_vld_q;
    tag2_id_d        = tag1_id_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q           <= 1'b0;
      rptr_q           <= 1'b0;
      ram_write_en_q   <= 1'b0;
      ram_waddr_q      <= '0;
      ram_write_data_q <= '0;
      ram_raddr_q      <= '0;
      tag1_vld_q       <= 1'b0;
      tag1_id_q        <= 1'b0;
      tag2_vld_q       <= 1'b0;
      tag2_id_q        <= 1'b0;
    end else begin
      wptr_q           <= wptr_d;
      rptr_q           <= rptr_d;
      ram_write_en_q   <= ram_write_en_d;
      ram_waddr_q      <= ram_waddr_d;
      ram_write_data_q <= ram_write_data_d;
      ram_raddr_q      <= ram_raddr_d;
      tag1_vld_q       <= tag1_vld_d;
      tag1_id_q        <= tag1_id_d;
      tag2_vld_q       <= tag2_vld_d;
      tag2_id_q        <= tag2_id_d;
    end
  end

  always_comb begin
    ram_waddr      = ram_waddr_q;
    ram_write_data = ram_write_data_q;
    ram_write_en   = ram_write_en_q;
    ram_raddr      = ram_raddr_q;
    r0_valid       = tag2_vld_q & ~tag2_id_q;
    r1_valid       = tag2_vld_q &  tag2_id_q;
    r0_data        = r0_valid ? ram_read_data : '0;
    r1_data        = r1_valid ? ram_read_data : '0;
  end

endmodule
`default_nettype wire

// File: tb/tb_ram_port_arbiter.sv
`default_nettype none
// tb_ram_port_arbiter: randomized plus directed stimulus against a queue-based
// reference model of the arbiter, with a behavioural RAM attached.
module tb_ram_port_arbiter;

  localparam int SIZE = 8;
  localparam int DEPTH = 8;
  localparam int AW = 3;
  localparam logic [SIZE-1:0] INIT [DEPTH] =
    '{8'h11, 8'h2B, 8'h4C, 8'h5D, 8'h6E, 8'h8F, 8'h9A, 8'h77};

  logic clk = 1'b0;
  logic rst;
  logic            wreq [2];
  logic [AW-1:0]   waddr [2];
  logic [SIZE-1:0] wdata [2];
  logic            rreq [2];
  logic [AW-1:0]   raddr [2];
  logic w0_grant, w1_grant, r0_grant, r1_grant, r0_valid, r1_valid;
  logic [SIZE-1:0] r0_data, r1_data, ram_write_data, ram_read_data;
  logic [AW-1:0]   ram_waddr, ram_raddr;
  logic            ram_write_en;

  always #5 clk = ~clk;

  ram_port_arbiter #(.SIZE(SIZE), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .w0_req(wreq[0]), .w0_addr(waddr[0]), .w0_data(wdata[0]), .w0_grant(w0_grant),
    .w1_req(wreq[1]), .w1_addr(waddr[1]), .w1_data(wdata[1]), .w1_grant(w1_grant),
    .r0_req(rreq[0]), .r0_addr(raddr[0]), .r0_grant(r0_grant),
    .r0_valid(r0_valid), .r0_data(r0_data),
    .r1_req(rreq[1]), .r1_addr(raddr[1]), .r1_grant(r1_grant),
    .r1_valid(r1_valid), .r1_data(r1_data),
    .ram_waddr(ram_waddr), .ram_write_data(ram_write_data),
    .ram_write_en(ram_write_en), .ram_raddr(ram_raddr),
    .ram_read_data(ram_read_data)
  );

  // Simple dual-port RAM, registered read (old data on same-edge write).
  logic [SIZE-1:0] mem [DEPTH] = INIT;
  always @(posedge clk) begin
    if (ram_write_en) mem[ram_waddr] <= ram_write_data;
    ram_read_data <= mem[ram_raddr];
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state.
  typedef struct { int due; int id; logic [SIZE-1:0] data; } rd_t;
  rd_t             rq [$];
  logic [SIZE-1:0] shadow [DEPTH] = INIT;
  int              wptr_m = 0, rptr_m = 0, cyc = 0;
  bit              exp_we = 0;
  logic [AW-1:0]   exp_waddr = '0, exp_raddr = '0;
  logic [SIZE-1:0] exp_wdata = '0;
  bit              wg_last [2];
  bit              rg_last [2];

  function automatic int rr_pick(input bit q0, input bit q1, input int ptr);
    if (q0 && q1) return ptr;
    if (q0) return 0;
    if (q1) return 1;
    return -1;
  endfunction

  // Inputs are stable from posedge+1; decisions are checked mid-cycle.
  task automatic run_cycle();
    int wwin, rwin;
    bit e0, e1, ev0, ev1;
    logic [SIZE-1:0] ed;
    #3;
    wwin = rr_pick(wreq[0], wreq[1], wptr_m);
    e0 = rreq[0] && !(wwin >= 0 && raddr[0] == waddr[wwin]);
    e1 = rreq[1] && !(wwin >= 0 && raddr[1] == waddr[wwin]);
    rwin = rr_pick(e0, e1, rptr_m);
    check_eq("w0_grant", w0_grant, wwin == 0);
    check_eq("w1_grant", w1_grant, wwin == 1);
    check_eq("r0_grant", r0_grant, rwin == 0);
    check_eq("r1_grant", r1_grant, rwin == 1);
    ev0 = 0; ev1 = 0; ed = '0;
    if (rq.size() > 0 && rq[0].due == cyc) begin
      ev0 = rq[0].id == 0;
      ev1 = rq[0].id == 1;
      ed  = rq[0].data;
    end
    check_eq("r0_valid", r0_valid, ev0);
    check_eq("r1_valid", r1_valid, ev1);
    check_eq("r0_data", r0_data, ev0 ? ed : '0);
    check_eq("r1_data", r1_data, ev1 ? ed : '0);
    check_eq("ram_write_en", ram_write_en, exp_we);
    check_eq("ram_waddr", ram_waddr, exp_waddr);
    check_eq("ram_write_data", ram_write_data, exp_wdata);
    check_eq("ram_raddr", ram_raddr, exp_raddr);
    @(posedge clk);
    if (rq.size() > 0 && rq[0].due == cyc) void'(rq.pop_front());
    for (int i = 0; i < 2; i++) begin
      wg_last[i] = (wwin == i);
      rg_last[i] = (rwin == i);
    end
    if (rwin >= 0) begin
      rq.push_back('{cyc + 2, rwin, shadow[raddr[rwin]]});
      exp_raddr = raddr[rwin];
      rptr_m = 1 - rwin;
    end
    exp_we = (wwin >= 0);
    if (wwin >= 0) begin
      shadow[waddr[wwin]] = wdata[wwin];
      exp_waddr = waddr[wwin];
      exp_wdata = wdata[wwin];
      wptr_m = 1 - wwin;
    end
    cyc++;
    #1;
  endtask

  task automatic new_random_inputs();
    for (int i = 0; i < 2; i++) begin
      if (!wreq[i] || wg_last[i]) begin
        wreq[i]  = ($urandom % 4) != 0;
        waddr[i] = AW'($urandom_range(0, 3));
        wdata[i] = SIZE'($urandom);
      end
      if (!rreq[i] || rg_last[i]) begin
        rreq[i]  = ($urandom % 4) != 0;
        raddr[i] = AW'($urandom_range(0, 3));
      end
    end
  endtask

  task automatic set_idle();
    for (int i = 0; i < 2; i++) begin
      wreq[i] = 0; rreq[i] = 0;
    end
  endtask

  task automatic model_reset();
    rq.delete();
    wptr_m = 0; rptr_m = 0;
    exp_we = 0; exp_waddr = '0; exp_wdata = '0; exp_raddr = '0;
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      waddr[i] = '0; wdata[i] = '0; raddr[i] = '0;
      wg_last[i] = 0; rg_last[i] = 0;
    end
    set_idle();
    rst = 1'b1;
    #1;
    check_eq("rst_write_en", ram_write_en, 1'b0);
    check_eq("rst_raddr", ram_raddr, '0);
    check_eq("rst_r0_valid", r0_valid, 1'b0);
    check_eq("rst_r1_data", r1_data, '0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Both writers competing: expect w0,w1,w0,w1 and four back-to-back writes.
    wreq[0] = 1; waddr[0] = 3'd1; wdata[0] = 8'hC1;
    wreq[1] = 1; waddr[1] = 3'd2; wdata[1] = 8'hC2;
    repeat (4) run_cycle();
    set_idle();
    run_cycle();

    // Write via w1 then read the same address via r0 the following cycle.
    wreq[1] = 1; waddr[1] = 3'd3; wdata[1] = 8'hA5;
    run_cycle();
    wreq[1] = 0; rreq[0] = 1; raddr[0] = 3'd3;
    run_cycle();
    rreq[0] = 0;
    repeat (3) run_cycle();

    // Collision: r1 waits for w0's write to addr 5, r0 proceeds.
    wreq[0] = 1; waddr[0] = 3'd5; wdata[0] = 8'h3C;
    rreq[1] = 1; raddr[1] = 3'd5;
    rreq[0] = 1; raddr[0] = 3'd6;
    run_cycle();
    wreq[0] = 0; rreq[0] = 0;
    run_cycle();
    rreq[1] = 0;
    repeat (3) run_cycle();

    // Continuous reads from both readers.
    rreq[0] = 1; raddr[0] = 3'd0;
    rreq[1] = 1; raddr[1] = 3'd7;
    repeat (8) run_cycle();
    set_idle();
    repeat (3) run_cycle();

    // Reset right after a write and a read transfer.
    wreq[0] = 1; waddr[0] = 3'd4; wdata[0] = 8'hE4;
    rreq[0] = 1; raddr[0] = 3'd2;
    run_cycle();
    set_idle();
    rst = 1'b1;
    #1;
    check_eq("midrst_write_en", ram_write_en, 1'b0);
    check_eq("midrst_raddr", ram_raddr, '0);
    model_reset();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_eq("midrst_r0_valid", r0_valid, 1'b0);
      check_eq("midrst_r1_valid", r1_valid, 1'b0);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    for (int a = 0; a < DEPTH; a++) shadow[a] = mem[a];
    check_eq("dropped_write", shadow[4], INIT[4]);
    cyc = 0;
    for (int i = 0; i < 2; i++) begin
      wreq[i] = 1; waddr[i] = AW'(i + 1); wdata[i] = SIZE'(8'h50 + i);
      rreq[i] = 1; raddr[i] = AW'(i + 5);
    end
    run_cycle();
    set_idle();

    // Idle period.
    repeat (5) run_cycle();

    // Randomized traffic on a narrow address range to provoke collisions.
    for (int t = 0; t < 400; t++) begin
      new_random_inputs();
      run_cycle();
    end
    set_idle();
    repeat (4) run_cycle();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares one simple dual-port RAM instance (registered read, 1-cycle latency; write on enable) between two write requesters and two read requesters.
- Arbitrates independently per port with round-robin.
- Registers all RAM-side signals.
- Returns read data to the correct requester with a one-cycle valid strobe.
- Enforces write-before-read ordering on same-address collisions.
- Sits between frame/pixel producers/consumers and the RAM; the RAM's rclk and wclk are both tied to clk.

Parameters:
- SIZE, 8, RAM word width in bits.
- DEPTH, 8, RAM entry count; address width AW = $clog2(DEPTH).

Ports:
- clk  in  1  single clock for arbiter and attached RAM.
- rst  in  1  asynchronous, active-high reset.
- w0_req, w1_req  in  1 each  write request; held with addr/data until granted.
- w0_addr, w1_addr  in  AW each  write address.
- w0_data, w1_data  in  SIZE each  write data.
- w0_grant, w1_grant  out  1 each  combinational grant; transfer occurs on the edge where req&grant.
- r0_req, r1_req  in  1 each  read request; held with addr until granted.
- r0_addr, r1_addr  in  AW each  read address.
- r0_grant, r1_grant  out  1 each  combinational read grant.
- r0_valid, r1_valid  out  1 each  one-cycle strobe: rN_data valid.
- r0_data, r1_data  out  SIZE each  read data; 0 when rN_valid low.
- ram_waddr  out  AW  registered RAM write address.
- ram_write_data  out  SIZE  registered RAM write data.
- ram_write_en  out  1  registered RAM write enable.
- ram_raddr  out  AW  registered RAM read address.
- ram_read_data  in  SIZE  RAM read data, valid 1 cycle after ram_raddr.

Behaviour:
- Reset (async, immediate):
  - wptr = rptr = requester 0 priority.
  - ram_write_en = 0; ram_waddr, ram_write_data, ram_raddr = 0.
  - Read tag pipeline cleared; all rN_valid = 0; all rN_data = 0.
  - Grants are combinational and follow the reset-state pointers.
- Write arbitration:
  - At most one wN_grant per cycle; grant only to a requesting writer.
  - With both requesting, grant the writer named by wptr.
  - On any write transfer, wptr is set to the other writer. With no transfer, wptr holds.
- Write pipeline:
  - On a transfer edge: ram_waddr/ram_write_data are loaded and ram_write_en = 1 for exactly that cycle.
  - The RAM commits the word on the next edge.
  - No transfer: ram_write_en = 0; ram_waddr and ram_write_data hold.
  - Back-to-back writes are allowed at 1 per cycle.
- Read arbitration:
  - Same round-robin rule using rptr.
  - A reader is ineligible in any cycle where its rN_addr equals the address of the write being granted that same cycle. This is the collision rule.
  - If the rptr winner is ineligible and the other reader is requesting and eligible, the other reader is granted.
  - rptr changes only on an actual read grant.
- Read pipeline, for a grant in cycle n:
  - ram_raddr is loaded at the end of cycle n; the requester ID is tagged alongside.
  - The RAM returns data in cycle n+2.
  - rN_valid = 1 in cycle n+2 for the tagged requester only; rN_data = ram_read_data; the other reader's data = 0.
  - Throughput 1 read/cycle; tags stay in order.
- Ordering:
  - A read granted in any cycle after a write transfer to the same address returns the new data.
  - A collision-stalled read is granted next cycle (if it wins arbitration) and returns the new data.
  - The RAM never sees raddr==waddr with write_en in the same cycle due to a same-cycle grant pair.
- Reset mid-operation: in-flight reads are discarded with no valid strobe; a registered-but-uncommitted write is dropped (ram_write_en forced 0).
- Idle: no requests -> no grants, ram_write_en = 0, ram_raddr holds.

Test Plan:
- After reset, w0_req=w1_req=1 for 4 cycles (addr 1/2) -> grants w0,w1,w0,w1; ram_write_en high 4 consecutive cycles; ram_waddr sequence 1,2,1,2.
- Write 0xA5 to addr 3 via w1; r0 reads addr 3 in the following cycle -> r0_grant one cycle after w1_grant; r0_valid 2 cycles after r0_grant, r0_data=0xA5, r1_valid stays 0.
- Same cycle: w0 writes 0x3C to addr 5, r1 reads addr 5, r0 reads addr 6 -> r1 withheld and r0 granted that cycle; r1 granted next cycle and returns 0x3C.
- r0 and r1 both continuously request (addr 0 and 7, RAM preloaded 0x11/0x77) -> alternating grants; valid strobes alternate r0/r1 each cycle with data 0x11/0x77, no bubbles.
- Assert rst one cycle after a read grant and a write grant -> no rN_valid ever appears for that read; ram_write_en low immediately; pointers back to requester 0 (simultaneous requests after reset grant w0/r0 first).
- No requests for 5 cycles -> all grants 0, ram_write_en 0, all rN_valid 0, rN_data 0.
